clk_meas_scheduler: RTL and testbench

CLK_MEAS_SCHEDULER -- requirements
Module: clk_meas_scheduler

---
 rtl/clk_meas_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_clk_meas_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_meas_scheduler.sv
// Round-robin scheduler that time-shares one gated counter across NCLK clock channels,
// steering the mux, windowing the count and collecting one rate result per channel.
module clk_meas_scheduler #(
  parameter int NCLK      = 16,
  parameter int CNT_WIDTH = 24,
  parameter int TIMEOUT   = 1024
) (
  input  logic                      clk_ref,
  input  logic                      reset,
  input  logic                      run,
  input  logic [NCLK-1:0]           chan_enable,
  input  logic [31:0]               gate_cycles,
  input  logic [7:0]                settle_cycles,
  input  logic [NCLK-1:0]           err_clear,
  output logic [3:0]                mux_sel,
  output logic                      ctr_clear,
  output logic                      ctr_gate,
  input  logic [CNT_WIDTH-1:0]      ctr_count,
  input  logic                      ctr_count_valid,
  output logic [NCLK*CNT_WIDTH-1:0] rate,
  output logic [NCLK-1:0]           rate_valid,
  output logic [NCLK-1:0]           timeout_err,
  output logic                      result_strobe,
  output logic [3:0]                result_chan,
  output logic                      sweep_done,
  output logic                      busy
);

  typedef enum logic [2:0] {IDLE, SETTLE, CLEAR, GATE, WAIT_VALID, STORE} state_e;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic [3:0]                ch_q, ch_d;
  logic                      first_q, first_d;
  logic [31:0]               cnt_q, cnt_d;
  logic [31:0]               gate_len_q, gate_len_d;
  logic [NCLK-1:0]           en_q, en_d;
  logic [NCLK*CNT_WIDTH-1:0] rate_q, rate_d;
  logic [NCLK-1:0]           rate_valid_q, rate_valid_d;
  logic [NCLK-1:0]           timeout_err_q, timeout_err_d;

  logic [4:0] rr_base, rr_idx;
  logic [3:0] rr_pick;
  logic       rr_found;
  logic [3:0] hi_ch;
  logic [7:0] settle_len;
  logic       timeout_hit, store_hit, advance;

  always_ff @(posedge clk_ref) begin
    if (reset) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      first_q       <= 1'b1;
      cnt_q         <= '0;
      gate_len_q    <= '0;
      en_q          <= '0;
      rate_q        <= '0;
      rate_valid_q  <= '0;
      timeout_err_q <= '0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      first_q       <= first_d;
      cnt_q         <= cnt_d;
      gate_len_q    <= gate_len_d;
      en_q          <= en_d;
      rate_q        <= rate_d;
      rate_valid_q  <= rate_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Search starts one past the last served channel, or at 0 straight after reset.
  always_comb begin
    rr_pick  = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_base  = first_q ? 5'd0 : ({1'b0, ch_q} + 5'd1);
    if (rr_base >= 5'(NCLK)) rr_base = 5'd0;
    for (int i = 0; i < NCLK; i++) begin
      rr_idx = rr_base + 5'(i);
      if (rr_idx >= 5'(NCLK)) rr_idx = rr_idx - 5'(NCLK);
      if (!rr_found && chan_enable[rr_idx[3:0]]) begin
        rr_pick  = rr_idx[3:0];
        rr_found = 1'b1;
      end
    end
  end

  // The end of a sweep is judged against the mask captured when this channel was chosen.
  always_comb begin
    hi_ch = '0;
    for (int i = 0; i < NCLK; i++) begin
      if (en_q[i]) hi_ch = 4'(i);
    end
  end

  assign settle_len  = (settle_cycles == 8'd0) ? 8'd1 : settle_cycles;
  assign timeout_hit = (state_q == WAIT_VALID) && run && !ctr_count_valid && (cnt_q == TIMEOUT_LAST);
  assign store_hit   = (state_q == STORE) && run;

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    first_d       = first_q;
    cnt_d         = cnt_q;
    gate_len_d    = gate_len_q;
    en_d          = en_q;
    rate_d        = rate_q;
    rate_valid_d  = rate_valid_q;
    timeout_err_d = timeout_err_q & ~err_clear;
    advance       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run && (chan_enable != '0)) advance = 1'b1;
      end
      SETTLE: begin
        if ((cnt_q + 32'd1) >= {24'd0, settle_len}) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      CLEAR: begin
        gate_len_d = (gate_cycles == 32'd0) ? 32'd1 : gate_cycles;
        state_d    = GATE;
        cnt_d      = '0;
      end
      GATE: begin
        if ((cnt_q + 32'd1) == gate_len_q) begin
          state_d = WAIT_VALID;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WAIT_VALID: begin
        if (ctr_count_valid) state_d = STORE;
        else if (timeout_hit) advance = 1'b1;
        else cnt_d = cnt_q + 32'd1;
      end
      STORE: advance = 1'b1;
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (chan_enable != '0) begin
        state_d = SETTLE;
        ch_d    = rr_pick;
        en_d    = chan_enable;
        first_d = 1'b0;
        cnt_d   = '0;
      end else begin
        state_d = IDLE;
      end
    end

    for (int i = 0; i < NCLK; i++) begin
      if (store_hit && (ch_q == 4'(i))) begin
        rate_d[i*CNT_WIDTH +: CNT_WIDTH] = ctr_count;
        rate_valid_d[i]                  = 1'b1;
      end
      if (timeout_hit && (ch_q == 4'(i))) begin
        timeout_err_d[i] = 1'b1;
        rate_valid_d[i]  = 1'b0;
      end
    end

    // Dropping run abandons the channel in flight without touching results.
    if (!run) begin
      state_d = IDLE;
      ch_d    = ch_q;
      en_d    = en_q;
      first_d = first_q;
      cnt_d   = '0;
    end
  end

  always_comb begin
    mux_sel       = ch_q;
    ctr_clear     = (state_q == CLEAR);
    ctr_gate      = (state_q == GATE);
    busy          = (state_q != IDLE);
    result_strobe = store_hit;
    result_chan   = ch_q;
    sweep_done    = (store_hit || timeout_hit) && (ch_q == hi_ch);
    rate          = rate_q;
    rate_valid    = rate_valid_q;
    timeout_err   = timeout_err_q;
  end

endmodule

// File: tb/tb_clk_meas_scheduler.sv
// Directed bench for clk_meas_scheduler: a small counter responder answers each gate window,
// and a linear sequence of steps checks selection order, window lengths, results and errors.
module tb_clk_meas_scheduler;

  localparam int NCLK = 16;
  localparam int CW   = 24;
  localparam int TO   = 16;

  logic                 clk_ref = 1'b0;
  logic                 reset;
  logic                 run;
  logic [NCLK-1:0]      chan_enable;
  logic [31:0]          gate_cycles;
  logic [7:0]           settle_cycles;
  logic [NCLK-1:0]      err_clear;
  logic [3:0]           mux_sel;
  logic                 ctr_clear;
  logic                 ctr_gate;
  logic [CW-1:0]        ctr_count;
  logic                 ctr_count_valid;
  logic [NCLK*CW-1:0]   rate;
  logic [NCLK-1:0]      rate_valid;
  logic [NCLK-1:0]      timeout_err;
  logic                 result_strobe;
  logic [3:0]           result_chan;
  logic                 sweep_done;
  logic                 busy;

  int checks   = 0;
  int failures = 0;

  logic [NCLK-1:0] resp_mask;
  logic [CW-1:0]   resp_count;

  clk_meas_scheduler #(.NCLK(NCLK), .CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk_ref(clk_ref), .reset(reset), .run(run), .chan_enable(chan_enable),
    .gate_cycles(gate_cycles), .settle_cycles(settle_cycles), .err_clear(err_clear),
    .mux_sel(mux_sel), .ctr_clear(ctr_clear), .ctr_gate(ctr_gate),
    .ctr_count(ctr_count), .ctr_count_valid(ctr_count_valid),
    .rate(rate), .rate_valid(rate_valid), .timeout_err(timeout_err),
    .result_strobe(result_strobe), .result_chan(result_chan),
    .sweep_done(sweep_done), .busy(busy)
  );

  always #5 clk_ref = ~clk_ref;

  // Counter model: one-cycle valid pulse three samples after the gate falls, if the channel answers.
  initial begin
    bit gate_seen;
    int delay;
    gate_seen       = 1'b0;
    delay           = 0;
    ctr_count       = '0;
    ctr_count_valid = 1'b0;
    forever begin
      @(negedge clk_ref);
      ctr_count_valid = 1'b0;
      if (ctr_gate) begin
        gate_seen = 1'b1;
        delay     = 0;
      end else if (gate_seen) begin
        delay++;
        if (delay == 3) begin
          gate_seen = 1'b0;
          if (resp_mask[mux_sel]) begin
            ctr_count       = resp_count;
            ctr_count_valid = 1'b1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic run_i, input logic [NCLK-1:0] en_i,
                               input logic [7:0] settle_i, input logic [31:0] gate_i);
    run           = run_i;
    chan_enable   = en_i;
    settle_cycles = settle_i;
    gate_cycles   = gate_i;
  endtask

  // Called at a sample where the next cycle is SETTLE; returns at the first sample after the gate.
  task automatic measureChannel(input int new_gate, output int settle_n, output int gate_n,
                                output logic [3:0] mux_n);
    bit found;
    settle_n = 0;
    gate_n   = 0;
    mux_n    = '0;
    found    = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk_ref);
      if (ctr_clear) found = 1'b1;
      else if (busy) settle_n++;
    end
    checkOutput("clear_seen", 32'(found), 32'd1);
    mux_n = mux_sel;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk_ref);
      if (ctr_gate) begin
        gate_n++;
        if (gate_n == 1 && new_gate >= 0) gate_cycles = 32'(new_gate);
      end else begin
        found = 1'b1;
      end
    end
    checkOutput("gate_end_seen", 32'(found), 32'd1);
  endtask

  task automatic waitResult(output logic got, output logic [3:0] ch, output logic done);
    got  = 1'b0;
    ch   = '0;
    done = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk_ref);
      if (result_strobe) begin
        got  = 1'b1;
        ch   = result_chan;
        done = sweep_done;
      end
    end
    checkOutput("strobe_seen", 32'(got), 32'd1);
  endtask

  initial begin
    int         settle_n, gate_n, wait_n, strobes;
    logic [3:0] mux_n, ch_n;
    logic       got, done, found;

    reset      = 1'b1;
    err_clear  = '0;
    resp_mask  = '1;
    resp_count = 24'h001234;
    applyStimulus(1'b0, 16'h0000, 8'd0, 32'd0);
    repeat (3) @(negedge clk_ref);

    checkOutput("rst_mux_sel", 32'(mux_sel), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_gate", 32'(ctr_gate), 32'd0);
    checkOutput("rst_clear", 32'(ctr_clear), 32'd0);
    checkOutput("rst_rate_valid", 32'(rate_valid), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("rst_rate_zero", 32'(rate == '0), 32'd1);
    reset = 1'b0;
    @(negedge clk_ref);
    checkOutput("idle_no_run_busy", 32'(busy), 32'd0);

    $display("[TB] two-channel sweep 0x0005, settle 4, gate 100");
    applyStimulus(1'b1, 16'h0005, 8'd4, 32'd100);
    measureChannel(-1, settle_n, gate_n, mux_n);
    checkOutput("t1_settle_ch0", 32'(settle_n), 32'd4);
    checkOutput("t1_mux_ch0", 32'(mux_n), 32'd0);
    checkOutput("t1_gate_ch0", 32'(gate_n), 32'd100);
    waitResult(got, ch_n, done);
    checkOutput("t1_chan_ch0", 32'(ch_n), 32'd0);
    checkOutput("t1_done_ch0", 32'(done), 32'd0);
    measureChannel(-1, settle_n, gate_n, mux_n);
    checkOutput("t1_mux_ch2", 32'(mux_n), 32'd2);
    checkOutput("t1_gate_ch2", 32'(gate_n), 32'd100);
    waitResult(got, ch_n, done);
    checkOutput("t1_chan_ch2", 32'(ch_n), 32'd2);
    checkOutput("t1_done_ch2", 32'(done), 32'd1);
    measureChannel(-1, settle_n, gate_n, mux_n);
    checkOutput("t1_mux_wrap", 32'(mux_n), 32'd0);
    checkOutput("t1_rate0", 32'(rate[0*CW +: CW]), 32'h001234);
    checkOutput("t1_rate2", 32'(rate[2*CW +: CW]), 32'h001234);
    checkOutput("t1_rate_valid", 32'(rate_valid), 32'h0005);
    waitResult(got, ch_n, done);
    checkOutput("t1_chan_wrap", 32'(ch_n), 32'd0);

    $display("[TB] zero settle and zero gate");
    settle_cycles = 8'd0;
    gate_cycles   = 32'd0;
    resp_count    = 24'h00ABCD;
    measureChannel(-1, settle_n, gate_n, mux_n);
    checkOutput("t2_settle_min", 32'(settle_n), 32'd1);
    checkOutput("t2_gate_min", 32'(gate_n), 32'd1);
    checkOutput("t2_mux", 32'(mux_n), 32'd2);
    waitResult(got, ch_n, done);
    checkOutput("t2_chan", 32'(ch_n), 32'd2);
    checkOutput("t2_done", 32'(done), 32'd1);

    $display("[TB] channel 1 timeout and error clearing");
    applyStimulus(1'b1, 16'h0006, 8'd2, 32'd10);
    measureChannel(3, settle_n, gate_n, mux_n);
    checkOutput("t3_mux_ch1", 32'(mux_n), 32'd1);
    checkOutput("t3_gate_held", 32'(gate_n), 32'd10);
    waitResult(got, ch_n, done);
    checkOutput("t3_chan_ch1", 32'(ch_n), 32'd1);
    checkOutput("t3_rate2_pre", 32'(rate[2*CW +: CW]), 32'h00ABCD);
    waitResult(got, ch_n, done);
    checkOutput("t3_chan_ch2", 32'(ch_n), 32'd2);
    resp_mask = ~16'h0002;
    measureChannel(-1, settle_n, gate_n, mux_n);
    checkOutput("t3_mux_ch1_again", 32'(mux_n), 32'd1);
    wait_n = 0;
    for (int i = 0; i < 40 && !timeout_err[1]; i++) begin
      @(negedge clk_ref);
      wait_n++;
    end
    checkOutput("t3_timeout_cycles", 32'(wait_n), 32'd16);
    checkOutput("t3_timeout_err", 32'(timeout_err), 32'h0002);
    checkOutput("t3_rate_valid", 32'(rate_valid), 32'h0005);
    checkOutput("t3_next_mux", 32'(mux_sel), 32'd2);
    checkOutput("t3_next_busy", 32'(busy), 32'd1);
    err_clear = 16'h0002;
    @(negedge clk_ref);
    err_clear = '0;
    checkOutput("t3_err_cleared", 32'(timeout_err), 32'h0000);
    waitResult(got, ch_n, done);
    checkOutput("t3_chan_ch2_b", 32'(ch_n), 32'd2);
    measureChannel(-1, settle_n, gate_n, mux_n);
    checkOutput("t3_mux_ch1_c", 32'(mux_n), 32'd1);
    repeat (15) @(negedge clk_ref);
    err_clear   = 16'h0002;
    gate_cycles = 32'd100;
    @(negedge clk_ref);
    err_clear = '0;
    checkOutput("t3_set_beats_clear", 32'(timeout_err), 32'h0002);

    $display("[TB] run dropped at gate cycle 50");
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_ref);
      found = ctr_gate;
    end
    checkOutput("t4_gate_seen", 32'(found), 32'd1);
    repeat (49) @(negedge clk_ref);
    run = 1'b0;
    @(negedge clk_ref);
    checkOutput("t4_gate_drop", 32'(ctr_gate), 32'd0);
    checkOutput("t4_busy_drop", 32'(busy), 32'd0);
    strobes = 0;
    for (int i = 0; i < 30; i++) begin
      if (result_strobe) strobes++;
      @(negedge clk_ref);
    end
    checkOutput("t4_no_strobe", 32'(strobes), 32'd0);
    checkOutput("t4_rate0_kept", 32'(rate[0*CW +: CW]), 32'h001234);
    checkOutput("t4_rate2_kept", 32'(rate[2*CW +: CW]), 32'h00ABCD);
    checkOutput("t4_rate_valid_kept", 32'(rate_valid), 32'h0005);

    $display("[TB] reset during gate, then single channel 15");
    run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_ref);
      found = ctr_gate;
    end
    checkOutput("t5_gate_seen", 32'(found), 32'd1);
    repeat (10) @(negedge clk_ref);
    reset = 1'b1;
    @(negedge clk_ref);
    checkOutput("t5_rst_gate", 32'(ctr_gate), 32'd0);
    checkOutput("t5_rst_busy", 32'(busy), 32'd0);
    checkOutput("t5_rst_mux", 32'(mux_sel), 32'd0);
    checkOutput("t5_rst_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("t5_rst_rate_valid", 32'(rate_valid), 32'd0);
    checkOutput("t5_rst_rate_zero", 32'(rate == '0), 32'd1);
    checkOutput("t5_rst_strobe", 32'(result_strobe), 32'd0);
    checkOutput("t5_rst_done", 32'(sweep_done), 32'd0);
    applyStimulus(1'b1, 16'h8000, 8'd2, 32'd5);
    reset = 1'b0;
    measureChannel(-1, settle_n, gate_n, mux_n);
    checkOutput("t5_mux_ch15", 32'(mux_n), 32'd15);
    checkOutput("t5_settle", 32'(settle_n), 32'd2);
    checkOutput("t5_gate", 32'(gate_n), 32'd5);
    waitResult(got, ch_n, done);
    checkOutput("t5_chan", 32'(ch_n), 32'd15);
    checkOutput("t5_done", 32'(done), 32'd1);
    measureChannel(-1, settle_n, gate_n, mux_n);
    checkOutput("t5_mux_repeat", 32'(mux_n), 32'd15);
    waitResult(got, ch_n, done);
    checkOutput("t5_chan_repeat", 32'(ch_n), 32'd15);
    checkOutput("t5_done_repeat", 32'(done), 32'd1);
    @(negedge clk_ref);
    checkOutput("t5_rate15", 32'(rate[15*CW +: CW]), 32'h00ABCD);
    checkOutput("t5_rate_valid", 32'(rate_valid), 32'h8000);

    run = 1'b0;
    @(negedge clk_ref);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
